fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch initiator for the pipelined MIPS core.
- Owns the PC register and drives the fetch address to the instruction memory, which is a combinational word ROM.
- Takes the returned instruction word and registers it, with its PC and PC+8, into the IF/ID pipeline register.
- Applies stall, flush and redirect control from the hazard unit and the ID stage, and keeps a fetch counter.

Parameters:
- PC_INIT, 32'h0000_3000, reset PC and base address of instruction memory.
- IM_DEPTH, 4096, instruction memory size in 32-bit words; used only by the optional range check.

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- stall, input, 1, hold PC and IF/ID.
- flush, input, 1, insert a bubble into IF/ID.
- redirect, input, 1, branch/jump taken; next PC is redirect_pc.
- redirect_pc, input, 32, branch/jump target from ID.
- im_addr, output, 32, fetch address to instruction memory; equals pc_q.
- im_instr, input, 32, instruction word returned combinationally for im_addr.
- instr_d, output, 32, IF/ID instruction.
- pc_d, output, 32, IF/ID PC.
- pc8_d, output, 32, IF/ID PC+8 (link address).
- valid_d, output, 1, IF/ID holds a real instruction.
- exc_d, output, 1, IF/ID fetch-address exception flag (optional feature).
- fetch_cnt, output, 32, count of instructions accepted into IF/ID.

Behaviour:
- Reset (synchronous, active-high, wins over everything): pc_q=PC_INIT, instr_d=0, pc_d=0, pc8_d=0, valid_d=0, exc_d=0, fetch_cnt=0.
- im_addr = pc_q, combinational. Memory latency is zero; im_instr is sampled in the same cycle.
- PC next-state priority: reset > stall (hold) > redirect (redirect_pc) > pc_q+4.
  - Additions wrap modulo 2^32.
  - redirect_pc is not realigned.
- Delay-slot semantics: redirect never discards the instruction fetched in the same cycle. That instruction is the delay slot and still enters IF/ID.
- IF/ID next-state priority: reset > stall (hold all fields) > flush (instr_d=0, valid_d=0, exc_d=0, pc_d/pc8_d=pc_q/pc_q+8) > load.
  - Load sets instr_d=im_instr, pc_d=pc_q, pc8_d=pc_q+8, valid_d=1.
- stall together with flush: stall wins; flush is ignored that cycle.
- stall together with redirect: the redirect is ignored; ID reasserts it once released.
- flush together with redirect: the PC takes redirect_pc and IF/ID takes the bubble.
- fetch_cnt increments by 1 on every load-case cycle only (not reset, stall or flush). It wraps 0xFFFF_FFFF -> 0.
- Logical state machine, derived from inputs with no extra flop: RUN (load) / HOLD (stall) / BUBBLE (flush). No multi-cycle states.
- Reset released mid-stream: the first fetch after reset is at PC_INIT in the first cycle reset is low. The result is visible in IF/ID one cycle later.

Optional Feature:
- Macro: FETCH_ADDR_CHECK_EN.
- Defined:
  - A fetch is bad if pc_q[1:0]!=0 or pc_q<PC_INIT or pc_q>=PC_INIT+4*IM_DEPTH.
  - On a load with a bad address: instr_d=0 (nop), exc_d=1, valid_d=1, fetch_cnt still increments.
  - The PC still advances normally; the exception handler redirects.
- Not defined: exc_d is constant 0 and there is no comparator logic. The port is always present.

Decomposition:
- Shared package: PC_INIT_DEFAULT, NOP_INSTR (32'h0), and the AdEL exception code constant.
- One natural sub-module: if_id_reg, the IF/ID register with stall/flush/reset priority.
- fetch_unit holds the PC logic, next-PC mux, optional range check and counter.

Test Plan:
- Reset held 3 cycles then released, ROM words W0,W1,W2 -> im_addr 0x3000,0x3004,0x3008; instr_d=W0 with pc_d=0x3000, pc8_d=0x3008, valid_d=1 one cycle after release; fetch_cnt=1.
- stall high 2 cycles at pc_q=0x3008 -> im_addr holds 0x3008; instr_d/pc_d/fetch_cnt unchanged; resumes 0x300C after release.
- redirect=1, redirect_pc=0x3100 at pc_q=0x3010 -> next im_addr=0x3100; instruction at 0x3010 (delay slot) still loaded into IF/ID.
- stall+flush together, then flush alone -> first cycle holds IF/ID; second cycle instr_d=0, valid_d=0, fetch_cnt unchanged.
- FETCH_ADDR_CHECK_EN defined, redirect_pc=0x3002 then redirect_pc=0x7000 -> both fetches give exc_d=1 with instr_d=0; a following fetch at 0x3004 gives exc_d=0.
- reset asserted mid-run while stall=1 and redirect=1 -> next cycle pc_q=0x3000, valid_d=0, fetch_cnt=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// The address range check is built only when FETCH_ADDR_CHECK_EN is defined.
package fetch_unit_pkg;

    localparam logic [31:0] PC_INIT_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL        = 5'd4;

    // Per-cycle behaviour of the stage, decoded from stall/flush with no flop behind it.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } fetch_mode_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        valid;
        logic        exc;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: fetch address out, instruction word back in the same cycle.
interface fetch_unit_if;

    logic [31:0] im_addr;
    logic [31:0] im_instr;

    modport master (output im_addr, input im_instr);
    modport slave  (input im_addr, output im_instr);

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: reset > hold > bubble > load.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  fetch_mode_e i_mode,
    input  if_id_t      i_entry,
    output if_id_t      o_q
);

    if_id_t r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            unique case (i_mode)
                HOLD:   r_q <= r_q;
                // A bubble still records the PC it displaced, so later stages can see where it sat.
                BUBBLE: r_q <= '{instr: NOP_INSTR, pc: i_entry.pc, pc8: i_entry.pc8,
                                 valid: 1'b0, exc: 1'b0};
                RUN:    r_q <= i_entry;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC select, IF/ID load and fetch counter.
// Define FETCH_ADDR_CHECK_EN to flag misaligned or out-of-range fetch addresses on exc_d.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_INIT  = PC_INIT_DEFAULT,
    parameter int          IM_DEPTH = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    fetch_unit_if.master       imem,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc_d,
    output logic [31:0]        pc8_d,
    output logic               valid_d,
    output logic               exc_d,
    output logic [31:0]        fetch_cnt
);

    generate
        if (IM_DEPTH < 1) begin : g_bad_depth
            $error("fetch_unit: IM_DEPTH must be at least 1");
        end
    endgenerate

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_fetch_cnt;
    logic        w_bad;
    fetch_mode_e w_mode;
    if_id_t      w_entry;
    if_id_t      w_if_id;

    always_comb begin
        w_mode = RUN;
        if (stall) begin
            w_mode = HOLD;
        end else if (flush) begin
            w_mode = BUBBLE;
        end
    end

    // Stall blocks redirect too; ID keeps the redirect asserted until the stall lifts.
    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (stall) begin
            w_pc_next = r_pc;
        end else if (redirect) begin
            w_pc_next = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_INIT;
        end else begin
            r_pc <= w_pc_next;
        end
    end

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic [32:0] PC_END = {1'b0, PC_INIT} + 33'(4 * IM_DEPTH);

    assign w_bad = (r_pc[1:0] != 2'b00) || (r_pc < PC_INIT) || ({1'b0, r_pc} >= PC_END);
`else
    assign w_bad = 1'b0;
`endif

    assign w_entry = '{instr: (w_bad ? NOP_INSTR : imem.im_instr),
                       pc:    r_pc,
                       pc8:   r_pc + 32'd8,
                       valid: 1'b1,
                       exc:   w_bad};

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .i_mode  (w_mode),
        .i_entry (w_entry),
        .o_q     (w_if_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= '0;
        end else if (w_mode == RUN) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign imem.im_addr = r_pc;
    assign instr_d      = w_if_id.instr;
    assign pc_d         = w_if_id.pc;
    assign pc8_d        = w_if_id.pc8;
    assign valid_d      = w_if_id.valid;
    assign exc_d        = w_if_id.exc;
    assign fetch_cnt    = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a combinational ROM returning {16'hC0DE, addr[15:0]}.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        exc_d;
    logic [31:0] fetch_cnt;

    int n_vec = 0;
    int n_bad = 0;

    fetch_unit_if imem ();

    assign imem.im_instr = {16'hC0DE, imem.im_addr[15:0]};

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc8_d       (pc8_d),
        .valid_d     (valid_d),
        .exc_d       (exc_d),
        .fetch_cnt   (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of controls, then sample #1 after the edge.
    task automatic step(input string name, input logic rst, input logic stl, input logic fls,
                        input logic rdr, input logic [31:0] rpc);
        reset       = rst;
        stall       = stl;
        flush       = fls;
        redirect    = rdr;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
        $display("%-12s im_addr=%h instr_d=%h pc_d=%h pc8_d=%h valid=%b exc=%b cnt=%0d",
                 name, imem.im_addr, instr_d, pc_d, pc8_d, valid_d, exc_d, fetch_cnt);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] ins,
                              input logic [31:0] pc, input logic v, input logic e,
                              input logic [31:0] cnt);
        check({tag, ".im_addr"}, imem.im_addr, addr);
        check({tag, ".instr_d"}, instr_d, ins);
        check({tag, ".pc_d"}, pc_d, pc);
        check({tag, ".pc8_d"}, pc8_d, (pc == 32'h0 && !v && ins == 32'h0 && cnt == 32'h0) ? 32'h0 : pc + 32'd8);
        check({tag, ".valid_d"}, {31'b0, valid_d}, {31'b0, v});
        check({tag, ".exc_d"}, {31'b0, exc_d}, {31'b0, e});
        check({tag, ".fetch_cnt"}, fetch_cnt, cnt);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_ifid("rst", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        step("run0", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_ifid("run0", 32'h3004, 32'hC0DE3000, 32'h3000, 1'b1, 1'b0, 32'd1);
        step("run1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_ifid("run1", 32'h3008, 32'hC0DE3004, 32'h3004, 1'b1, 1'b0, 32'd2);

        step("stall0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_ifid("stall0", 32'h3008, 32'hC0DE3004, 32'h3004, 1'b1, 1'b0, 32'd2);
        step("stall1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_ifid("stall1", 32'h3008, 32'hC0DE3004, 32'h3004, 1'b1, 1'b0, 32'd2);
        step("resume", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_ifid("resume", 32'h300C, 32'hC0DE3008, 32'h3008, 1'b1, 1'b0, 32'd3);
        step("run2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_ifid("run2", 32'h3010, 32'hC0DE300C, 32'h300C, 1'b1, 1'b0, 32'd4);

        // Instruction at 0x3010 is the delay slot and must still load.
        step("redirect", 1'b0, 1'b0, 1'b0, 1'b1, 32'h3100);
        check_ifid("redir", 32'h3100, 32'hC0DE3010, 32'h3010, 1'b1, 1'b0, 32'd5);
        step("target", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_ifid("target", 32'h3104, 32'hC0DE3100, 32'h3100, 1'b1, 1'b0, 32'd6);

        step("stall+flush", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check_ifid("stfl", 32'h3104, 32'hC0DE3100, 32'h3100, 1'b1, 1'b0, 32'd6);
        step("flush", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check_ifid("flush", 32'h3108, 32'h0, 32'h3104, 1'b0, 1'b0, 32'd6);
        step("flush+redir", 1'b0, 1'b0, 1'b1, 1'b1, 32'h3200);
        check_ifid("flrd", 32'h3200, 32'h0, 32'h3108, 1'b0, 1'b0, 32'd6);
        step("stall+redir", 1'b0, 1'b1, 1'b0, 1'b1, 32'h3300);
        check_ifid("strd", 32'h3200, 32'h0, 32'h3108, 1'b0, 1'b0, 32'd6);

        step("to3002", 1'b0, 1'b0, 1'b0, 1'b1, 32'h3002);
        check_ifid("to3002", 32'h3002, 32'hC0DE3200, 32'h3200, 1'b1, 1'b0, 32'd7);
`ifdef FETCH_ADDR_CHECK_EN
        step("to7000", 1'b0, 1'b0, 1'b0, 1'b1, 32'h7000);
        check_ifid("misalign", 32'h7000, 32'h0, 32'h3002, 1'b1, 1'b1, 32'd8);
        step("to3004", 1'b0, 1'b0, 1'b0, 1'b1, 32'h3004);
        check_ifid("range", 32'h3004, 32'h0, 32'h7000, 1'b1, 1'b1, 32'd9);
`else
        step("to7000", 1'b0, 1'b0, 1'b0, 1'b1, 32'h7000);
        check_ifid("misalign", 32'h7000, 32'hC0DE3002, 32'h3002, 1'b1, 1'b0, 32'd8);
        step("to3004", 1'b0, 1'b0, 1'b0, 1'b1, 32'h3004);
        check_ifid("range", 32'h3004, 32'hC0DE7000, 32'h7000, 1'b1, 1'b0, 32'd9);
`endif
        step("good", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_ifid("good", 32'h3008, 32'hC0DE3004, 32'h3004, 1'b1, 1'b0, 32'd10);

        step("reset_mid", 1'b1, 1'b1, 1'b0, 1'b1, 32'h5000);
        check_ifid("rstmid", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        step("rerun", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_ifid("rerun", 32'h3004, 32'hC0DE3000, 32'h3000, 1'b1, 1'b0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
